// File: rtl/sa_ram_pkg.sv
// -----------------------------------------------------------------------------
// sa_ram_pkg
// Shared definitions for the parametrised sa_ram_* RAM models:
//   - sa_ram_state_e   : init sequencer states (INIT sweep, READY)
//   - sa_ram_aw()      : address width for a given depth, never below 1 bit
//   - sa_ram_lane_merge: bitwise merge of new data into an old word under a
//                        per-bit mask (callers expand their lane mask first)
// -----------------------------------------------------------------------------
package sa_ram_pkg;

   typedef enum logic [0:0] {
      INIT  = 1'b0,
      READY = 1'b1
   } sa_ram_state_e;

   // Widest word the merge helper handles; callers cast to and from this width.
   localparam int SA_RAM_MAX_W = 1024;

   // Address width: clog2(depth), but at least one bit so a depth of 1 or 2
   // still yields a usable port.
   function automatic int sa_ram_aw(input int depth);
      int aw;
      aw = $clog2(depth);
      if (aw < 1) begin
         return 1;
      end else begin
         return aw;
      end
   endfunction

   // Bits of new_word replace bits of old_word wherever bit_mask is 1.
   function automatic logic [SA_RAM_MAX_W-1:0] sa_ram_lane_merge(
      input logic [SA_RAM_MAX_W-1:0] old_word,
      input logic [SA_RAM_MAX_W-1:0] new_word,
      input logic [SA_RAM_MAX_W-1:0] bit_mask
   );
      return (old_word & ~bit_mask) | (new_word & bit_mask);
   endfunction

endpackage

// File: rtl/sa_ram_init_seq.sv
// -----------------------------------------------------------------------------
// sa_ram_init_seq
// Post-reset clear sequencer. After reset it walks addresses 0..DEPTH-1, one
// per cycle, requesting a write of the clear value at each, then parks in
// READY until the next reset. With INIT_EN=0 it comes out of reset in READY.
//
// Ports
//   clk        in   clock
//   rst        in   asynchronous, active-high reset
//   init_busy  out  sweep in progress (registered)
//   init_we    out  sweep write request for this cycle
//   init_addr  out  sweep write address for this cycle
// -----------------------------------------------------------------------------
module sa_ram_init_seq
   import sa_ram_pkg::*;
#(
   parameter int DEPTH   = 64,
   parameter int AW      = 6,
   parameter bit INIT_EN = 1'b1
) (
   input  logic          clk,
   input  logic          rst,
   output logic          init_busy,
   output logic          init_we,
   output logic [AW-1:0] init_addr
);

   localparam sa_ram_state_e  RST_STATE = INIT_EN ? INIT : READY;
   localparam logic [AW-1:0]  LAST_ADDR = AW'(DEPTH - 1);

   sa_ram_state_e  state_r;
   sa_ram_state_e  state_nxt_s;
   logic [AW-1:0]  cnt_r;
   logic [AW-1:0]  cnt_nxt_s;
   logic           busy_r;

   // Next-state and counter logic; the counter stops on the last address.
   always_comb begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
      case (state_r)
         INIT: begin
            if (cnt_r == LAST_ADDR) begin
               state_nxt_s = READY;
               cnt_nxt_s   = cnt_r;
            end else begin
               state_nxt_s = INIT;
               cnt_nxt_s   = cnt_r + AW'(1);
            end
         end
         READY: begin
            state_nxt_s = READY;
            cnt_nxt_s   = cnt_r;
         end
         default: begin
            state_nxt_s = READY;
            cnt_nxt_s   = cnt_r;
         end
      endcase
   end

   // State, counter and busy flag registers; busy tracks the next state so it
   // drops right after the edge that writes the last address.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= RST_STATE;
         cnt_r   <= '0;
         busy_r  <= INIT_EN;
      end else begin
         state_r <= state_nxt_s;
         cnt_r   <= cnt_nxt_s;
         busy_r  <= (state_nxt_s == INIT);
      end
   end

   assign init_busy = busy_r;
   assign init_we   = busy_r;
   assign init_addr = cnt_r;

endmodule

// File: rtl/sa_ram_rwsp_param.sv
// -----------------------------------------------------------------------------
// sa_ram_rwsp_param
// Parametrised RAM with one synchronous write port and one read port made of a
// registered address stage (ra -> ra_d on re) followed by an enabled output
// register (M[ra_d] -> dout on ore). Supports lane write masking, a selectable
// read-during-write policy and an optional post-reset clear sweep.
//
// Ports
//   clk            in   clock
//   rst            in   asynchronous, active-high reset
//   ra             in   read address
//   re             in   read address enable
//   ore            in   output register enable
//   dout           out  registered read data (0 for out-of-range ra_d)
//   wa             in   write address
//   we             in   write enable
//   wmask          in   per-lane write enable, 1 = write lane
//   di             in   write data
//   pwrbus_ram_pd  in   power-down bus, accepted and ignored
//   init_busy      out  clear sweep in progress
//   wr_drop        out  sticky: a write was discarded (during sweep / wa>=DEPTH)
// -----------------------------------------------------------------------------
module sa_ram_rwsp_param
   import sa_ram_pkg::*;
#(
   parameter int               DEPTH    = 64,
   parameter int               WIDTH    = 14,
   parameter int               LANE     = WIDTH,
   parameter bit               BYPASS   = 1'b0,
   parameter bit               INIT_EN  = 1'b1,
   parameter logic [WIDTH-1:0] INIT_VAL = '0,
   localparam int              AW       = sa_ram_aw(DEPTH),
   localparam int              NL       = WIDTH / LANE
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [AW-1:0]    ra,
   input  logic             re,
   input  logic             ore,
   output logic [WIDTH-1:0] dout,
   input  logic [AW-1:0]    wa,
   input  logic             we,
   input  logic [NL-1:0]    wmask,
   input  logic [WIDTH-1:0] di,
   input  logic [31:0]      pwrbus_ram_pd,
   output logic             init_busy,
   output logic             wr_drop
);

   // One bit wider than the address so DEPTH = 2**AW is representable.
   localparam logic [AW:0] DEPTH_LIM = (AW + 1)'(DEPTH);

   logic [WIDTH-1:0] mem_r [DEPTH];

   logic             init_busy_s;
   logic             init_we_s;
   logic [AW-1:0]    init_addr_s;

   logic [WIDTH-1:0] bit_mask_s;
   logic [WIDTH-1:0] wr_old_s;
   logic [WIDTH-1:0] wr_merged_s;
   logic [WIDTH-1:0] rd_word_s;
   logic             wa_ok_s;
   logic             rad_ok_s;
   logic             drop_set_s;

   logic             mem_we_s;
   logic [AW-1:0]    mem_wa_s;
   logic [WIDTH-1:0] mem_wd_s;

   logic [AW-1:0]    ra_d_r;
   logic [WIDTH-1:0] dout_r;
   logic             wr_drop_r;

   logic             unused_pwrbus_s;

   assign unused_pwrbus_s = ^pwrbus_ram_pd;

   sa_ram_init_seq #(
      .DEPTH   (DEPTH),
      .AW      (AW),
      .INIT_EN (INIT_EN)
   ) u_init_seq (
      .clk       (clk),
      .rst       (rst),
      .init_busy (init_busy_s),
      .init_we   (init_we_s),
      .init_addr (init_addr_s)
   );

   // Expand the lane mask to one bit per data bit.
   for (genvar i = 0; i < NL; i++) begin : g_lane_mask
      assign bit_mask_s[i*LANE +: LANE] = {LANE{wmask[i]}};
   end

   assign wa_ok_s  = ({1'b0, wa} < DEPTH_LIM);
   assign rad_ok_s = ({1'b0, ra_d_r} < DEPTH_LIM);

   // Old word at the write address, feeding the lane merge.
   always_comb begin
      wr_old_s = '0;
      if (wa_ok_s) begin
         wr_old_s = mem_r[wa];
      end else begin
         wr_old_s = '0;
      end
   end

   // Word as it will stand after the write; also the BYPASS=1 collision value.
   assign wr_merged_s = WIDTH'(sa_ram_lane_merge(SA_RAM_MAX_W'(wr_old_s),
                                                 SA_RAM_MAX_W'(di),
                                                 SA_RAM_MAX_W'(bit_mask_s)));

   // Read data selection: out-of-range reads give 0; a same-cycle write to
   // ra_d is forwarded only when BYPASS is set (otherwise the old word wins).
   always_comb begin
      rd_word_s = '0;
      if (!rad_ok_s) begin
         rd_word_s = '0;
      end else if (BYPASS && we && (wa == ra_d_r)) begin
         rd_word_s = wr_merged_s;
      end else begin
         rd_word_s = mem_r[ra_d_r];
      end
   end

   // Write port mux: the sweep owns the array while it runs.
   always_comb begin
      mem_we_s = 1'b0;
      mem_wa_s = wa;
      mem_wd_s = wr_merged_s;
      if (init_we_s) begin
         mem_we_s = 1'b1;
         mem_wa_s = init_addr_s;
         mem_wd_s = INIT_VAL;
      end else begin
         mem_we_s = we && wa_ok_s;
         mem_wa_s = wa;
         mem_wd_s = wr_merged_s;
      end
   end

   assign drop_set_s = we && (init_busy_s || !wa_ok_s);

   // Storage array; no reset so it maps onto distributed or block RAM.
   always_ff @(posedge clk) begin
      if (mem_we_s) begin
         mem_r[mem_wa_s] <= mem_wd_s;
      end
   end

   // Read address stage and output register, both frozen at 0 during the sweep.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ra_d_r <= '0;
         dout_r <= '0;
      end else if (init_busy_s) begin
         ra_d_r <= '0;
         dout_r <= '0;
      end else begin
         if (re) begin
            ra_d_r <= ra;
         end
         if (ore) begin
            dout_r <= rd_word_s;
         end
      end
   end

   // Sticky discarded-write flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_drop_r <= 1'b0;
      end else if (drop_set_s) begin
         wr_drop_r <= 1'b1;
      end
   end

   assign dout      = dout_r;
   assign init_busy = init_busy_s;
   assign wr_drop   = wr_drop_r;

endmodule

// File: tb/tb_sa_ram_rwsp_param.sv
// -----------------------------------------------------------------------------
// tb_sa_ram_rwsp_param
// Drives two instances from one stimulus stream:
//   A: DEPTH=64, WIDTH=14, LANE=7, BYPASS=0, INIT_VAL=0x155
//   B: DEPTH=48, WIDTH=16, LANE=8, BYPASS=1, INIT_VAL=0xC3A5
// Both share address width 6 and a 2-bit lane mask. A word-level reference
// model predicts every output after every clock edge.
// -----------------------------------------------------------------------------
module tb_sa_ram_rwsp_param;

   localparam int          NK            = 2;
   localparam int          C_DEPTH [NK]  = '{64, 48};
   localparam int          C_WIDTH [NK]  = '{14, 16};
   localparam int          C_LANE  [NK]  = '{7, 8};
   localparam bit          C_BYP   [NK]  = '{1'b0, 1'b1};
   localparam logic [15:0] C_INIT  [NK]  = '{16'h0155, 16'hC3A5};

   logic        clk = 1'b0;
   logic        rst;
   logic [5:0]  ra, wa;
   logic        re, ore, we;
   logic [1:0]  wmask;
   logic [15:0] di;
   logic [31:0] pwr;
   logic [13:0] dout_a;
   logic [15:0] dout_b;
   logic        busy_a, busy_b, drop_a, drop_b;

   int n_checks = 0;
   int n_errors = 0;

   // reference model state
   logic [15:0] m_mem  [NK][64];
   int          m_left [NK];
   logic [5:0]  m_rad  [NK];
   logic [15:0] m_dout [NK];
   logic        m_drop [NK];

   always #5 clk = ~clk;

   sa_ram_rwsp_param #(
      .DEPTH(64), .WIDTH(14), .LANE(7), .BYPASS(1'b0),
      .INIT_EN(1'b1), .INIT_VAL(14'h0155)
   ) u_dut_a (
      .clk(clk), .rst(rst), .ra(ra), .re(re), .ore(ore), .dout(dout_a),
      .wa(wa), .we(we), .wmask(wmask), .di(di[13:0]),
      .pwrbus_ram_pd(pwr), .init_busy(busy_a), .wr_drop(drop_a)
   );

   sa_ram_rwsp_param #(
      .DEPTH(48), .WIDTH(16), .LANE(8), .BYPASS(1'b1),
      .INIT_EN(1'b1), .INIT_VAL(16'hC3A5)
   ) u_dut_b (
      .clk(clk), .rst(rst), .ra(ra), .re(re), .ore(ore), .dout(dout_b),
      .wa(wa), .we(we), .wmask(wmask), .di(di),
      .pwrbus_ram_pd(pwr), .init_busy(busy_b), .wr_drop(drop_b)
   );

   task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      if (obs !== exp_v) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp_v, $time);
      end
   endtask

   // Bit b of the result comes from new_w if its lane is enabled, else old_w.
   function automatic logic [15:0] lane_merge(input logic [15:0] old_w, input logic [15:0] new_w,
                                              input logic [1:0] m, input int lane, input int width);
      logic [15:0] r;
      r = 16'h0000;
      for (int b = 0; b < width; b++) begin
         r[b] = m[b / lane] ? new_w[b] : old_w[b];
      end
      return r;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < NK; k++) begin
         m_left[k] = C_DEPTH[k];
         m_rad[k]  = 6'd0;
         m_dout[k] = 16'h0000;
         m_drop[k] = 1'b0;
      end
   endtask

   // Effect of one rising clock edge on each instance.
   task automatic model_edge();
      logic [15:0] nd;
      logic [15:0] old_w;
      if (rst) begin
         model_reset();
      end else begin
         for (int k = 0; k < NK; k++) begin
            if (m_left[k] > 0) begin
               m_mem[k][C_DEPTH[k] - m_left[k]] = C_INIT[k];
               if (we) m_drop[k] = 1'b1;
               m_left[k]--;
            end else begin
               nd = m_dout[k];
               if (ore) begin
                  if (int'(m_rad[k]) >= C_DEPTH[k]) begin
                     nd = 16'h0000;
                  end else begin
                     old_w = m_mem[k][m_rad[k]];
                     if (C_BYP[k] && we && (wa == m_rad[k]))
                        nd = lane_merge(old_w, di, wmask, C_LANE[k], C_WIDTH[k]);
                     else
                        nd = old_w;
                  end
               end
               if (we) begin
                  if (int'(wa) < C_DEPTH[k])
                     m_mem[k][wa] = lane_merge(m_mem[k][wa], di, wmask, C_LANE[k], C_WIDTH[k]);
                  else
                     m_drop[k] = 1'b1;
               end
               if (re) m_rad[k] = ra;
               m_dout[k] = nd;
            end
         end
      end
   endtask

   task automatic check_outputs();
      chk_val("dout_a", 32'(dout_a), 32'(m_dout[0]));
      chk_val("dout_b", 32'(dout_b), 32'(m_dout[1]));
      chk_val("busy_a", 32'(busy_a), 32'(m_left[0] > 0));
      chk_val("busy_b", 32'(busy_b), 32'(m_left[1] > 0));
      chk_val("drop_a", 32'(drop_a), 32'(m_drop[0]));
      chk_val("drop_b", 32'(drop_b), 32'(m_drop[1]));
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      check_outputs();
   endtask

   task automatic wr(input logic [5:0] a, input logic [15:0] d, input logic [1:0] m);
      wa = a; di = d; wmask = m; we = 1'b1;
      tick();
      we = 1'b0;
   endtask

   task automatic rd(input logic [5:0] a);
      ra = a; re = 1'b1;
      tick();
      re = 1'b0; ore = 1'b1;
      tick();
      ore = 1'b0;
   endtask

   initial begin
      int len_a, len_b;
      rst = 1'b1; ra = 6'd0; wa = 6'd0; re = 1'b0; ore = 1'b0; we = 1'b0;
      wmask = 2'b11; di = 16'h0000; pwr = 32'h0000_0000;
      model_reset();
      #1;
      chk_val("rst_dout_a", 32'(dout_a), 32'h0);
      chk_val("rst_dout_b", 32'(dout_b), 32'h0);
      chk_val("rst_busy_a", 32'(busy_a), 32'h1);
      chk_val("rst_drop_a", 32'(drop_a), 32'h0);
      tick(); tick();
      rst = 1'b0;

      // first sweep, with a write pulse that must be dropped
      for (int i = 0; i < 20; i++) begin
         we = (i == 5); wa = 6'd7; di = 16'h1111;
         tick();
      end
      we = 1'b0;
      chk_val("sweep_drop_a", 32'(drop_a), 32'h1);
      chk_val("sweep_drop_b", 32'(drop_b), 32'h1);

      // reset in the middle of the sweep
      rst = 1'b1;
      model_reset();
      #1;
      chk_val("midrst_dout_a", 32'(dout_a), 32'h0);
      chk_val("midrst_busy_a", 32'(busy_a), 32'h1);
      chk_val("midrst_busy_b", 32'(busy_b), 32'h1);
      chk_val("midrst_drop_a", 32'(drop_a), 32'h0);
      tick();
      rst = 1'b0;

      // full sweep length
      len_a = 0; len_b = 0;
      for (int i = 1; i <= 70; i++) begin
         tick();
         if (!busy_a && len_a == 0) len_a = i;
         if (!busy_b && len_b == 0) len_b = i;
      end
      chk_val("sweep_len_a", 32'(len_a), 32'd64);
      chk_val("sweep_len_b", 32'(len_b), 32'd48);

      rd(6'd0);
      chk_val("init0_a", 32'(dout_a), 32'h155);
      chk_val("init0_b", 32'(dout_b), 32'hC3A5);
      rd(6'd31);
      chk_val("init31_a", 32'(dout_a), 32'h155);
      chk_val("init31_b", 32'(dout_b), 32'hC3A5);
      rd(6'd63);
      chk_val("init63_a", 32'(dout_a), 32'h155);
      chk_val("oor63_b", 32'(dout_b), 32'h0);

      // latency and hold while ore=0 (even with writes to the same word)
      wr(6'd7, 16'h02A5, 2'b11);
      rd(6'd7);
      chk_val("lat_a", 32'(dout_a), 32'h2A5);
      chk_val("lat_b", 32'(dout_b), 32'h2A5);
      for (int i = 0; i < 5; i++) begin
         we = 1'b1; wa = 6'd7; di = 16'h0001; re = 1'b1; ra = 6'(i);
         tick();
         chk_val("hold_a", 32'(dout_a), 32'h2A5);
         chk_val("hold_b", 32'(dout_b), 32'h2A5);
      end
      we = 1'b0; re = 1'b0;

      // lane masking
      wr(6'd3, 16'hAAAA, 2'b11);
      wr(6'd3, 16'h1234, 2'b01);
      rd(6'd3);
      chk_val("mask_a", 32'(dout_a), 32'h2AB4);
      chk_val("mask_b", 32'(dout_b), 32'hAA34);

      // read-during-write collision
      wr(6'd5, 16'h0011, 2'b11);
      ra = 6'd5; re = 1'b1;
      tick();
      re = 1'b0;
      wa = 6'd5; di = 16'h3FFF; wmask = 2'b11; we = 1'b1; ore = 1'b1;
      tick();
      we = 1'b0;
      chk_val("coll_old_a", 32'(dout_a), 32'h0011);
      chk_val("coll_new_b", 32'(dout_b), 32'h3FFF);
      tick();
      ore = 1'b0;
      chk_val("coll_next_a", 32'(dout_a), 32'h3FFF);
      chk_val("coll_next_b", 32'(dout_b), 32'h3FFF);

      // address beyond DEPTH on the 48-word instance
      wr(6'd50, 16'h5A5A, 2'b11);
      chk_val("oor_drop_a", 32'(drop_a), 32'h0);
      chk_val("oor_drop_b", 32'(drop_b), 32'h1);
      rd(6'd50);
      chk_val("rd50_a", 32'(dout_a), 32'h1A5A);
      chk_val("rd50_b", 32'(dout_b), 32'h0);
      rd(6'd2);
      chk_val("alias2_b", 32'(dout_b), 32'hC3A5);
      rd(6'd18);
      chk_val("alias18_b", 32'(dout_b), 32'hC3A5);

      // randomized traffic with occasional resets
      for (int i = 0; i < 1500; i++) begin
         rst   = ($urandom_range(0, 299) == 0);
         we    = 1'($urandom_range(0, 1));
         re    = 1'($urandom_range(0, 1));
         ore   = 1'($urandom_range(0, 1));
         wa    = ($urandom_range(0, 1) == 1) ? 6'($urandom_range(0, 3)) : 6'($urandom_range(0, 63));
         ra    = ($urandom_range(0, 1) == 1) ? 6'($urandom_range(0, 3)) : 6'($urandom_range(0, 63));
         di    = 16'($urandom);
         wmask = 2'($urandom_range(0, 3));
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/sa_ram_rwsp_param.md
# sa_ram_rwsp_param

Parametrised two-port RAM model for the small-config FPGA RAM library: one synchronous write port and one read port with a registered address stage and an enabled output register.
- It is the generalised successor of the fixed-size `sa_ram_rwsp_<D>x<W>` models.
- Adds byte/lane write masking, a selectable read-during-write policy and a post-reset hardware clear sweep.
- Drops in wherever a fixed-size model is instantiated.

## Interface
- `DEPTH`, 64, number of words; any value ≥ 2, not necessarily a power of two
- `WIDTH`, 14, data bits per word
- `LANE`, WIDTH, write-mask granularity in bits; must divide WIDTH; `LANE`=WIDTH means no masking
- `BYPASS`, 0, read-during-write policy: 0 = old data, 1 = new (merged) data
- `INIT_EN`, 1, enable post-reset clear sweep
- `INIT_VAL`, 0, WIDTH-bit value written by the sweep
- `clk`  in  1  clock
- `rst`  in  1  asynchronous, active-high reset
- `ra`  in  AW = max(1, clog2(DEPTH))  read address
- `re`  in  1  read address enable
- `ore`  in  1  output register enable
- `dout`  out  WIDTH  registered read data
- `wa`  in  AW  write address
- `we`  in  1  write enable
- `wmask`  in  WIDTH/LANE  per-lane write enable, 1 = write lane
- `di`  in  WIDTH  write data
- `pwrbus_ram_pd`  in  32  power-down bus, accepted and ignored
- `init_busy`  out  1  clear sweep in progress
- `wr_drop`  out  1  sticky: a write was discarded because it arrived during the sweep or targeted an address ≥ DEPTH

## Operation
- **Reset values:** `dout`=0, `ra_d`=0, `init_busy`=INIT_EN, `wr_drop`=0, sweep counter=0.
- **FSM states:** INIT, READY.
  - Reset enters INIT if INIT_EN, otherwise READY.
  - INIT writes INIT_VAL to address `cnt`, one address per cycle, cnt 0..DEPTH-1.
  - On the cnt=DEPTH-1 write, INIT goes to READY; `cnt` does not wrap.
  - READY is absorbing until reset.
- **During INIT:**
  - `we` is ignored; each cycle with `we`=1 sets `wr_drop`.
  - `re` and `ore` are ignored; `ra_d` and `dout` hold at 0.
- **Write (READY):** when `we`=1 and `wa`<DEPTH, lane i of M[wa] takes `di` lane i where `wmask[i]`=1. Masked lanes keep their value.
- **Out-of-range write:** `wa`≥DEPTH drops the write and sets `wr_drop`.
- **Read address:** `ra_d` ← `ra` when `re`=1; otherwise it holds.
- **Output register:** when `ore`=1, `dout` ← M[`ra_d`]. If `ra_d`≥DEPTH, `dout` ← 0.
- **Collision:** `we`=1, `wa`=`ra_d`, `ore`=1 in the same cycle.
  - BYPASS=0: `dout` gets the pre-write word.
  - BYPASS=1: `dout` gets the pre-write word with the masked lanes of `di` substituted, i.e. exactly what M holds after the edge.
- Write to the address being captured into `ra_d` (`wa`=`ra`, `re`=1) is not a collision. The later `ore` reads the new data.

## Timing
- Read latency: `re` at edge N, `ore` at edge N+1, `dout` valid after edge N+1. Minimum two cycles from `ra` to `dout`.
- `dout` holds indefinitely while `ore`=0.
- Write is visible to any `ore` capture at a later edge.
- Sweep duration: exactly DEPTH cycles after `rst` deasserts. `init_busy` falls after the edge that writes DEPTH-1.
  - First READY-state `we` is accepted at the edge after `init_busy` is seen low.
- Reset mid-sweep or mid-operation: all registers return to reset values and the sweep restarts from 0. Array contents are undefined until the sweep completes.
- INIT_EN=0: array contents are undefined after reset and must not be read before being written.

## Structure
- Shared package `sa_ram_pkg`:
  - `sa_ram_state_e` {INIT, READY}
  - clog2-based address-width function
  - lane-merge function (old, new, mask)
- Sub-module `sa_ram_init_seq`:
  - owns the FSM and counter
  - outputs `init_busy`, `init_we`, `init_addr`
- Top level muxes the write port between the init sequencer and the user port.
- Array is a plain reg array, inferable as distributed or block RAM.

## Test plan
- **Sweep:** INIT_EN=1, INIT_VAL=0x155, DEPTH=64.
  - Release reset → `init_busy` high exactly 64 cycles.
  - Reading addresses 0, 31, 63 returns 0x155.
  - `we` pulse during sweep → write dropped and `wr_drop`=1.
- **Latency:** write 0x2A5 to address 7, `re` with `ra`=7, then `ore` next cycle → `dout`=0x2A5 one cycle after `ore`.
  - Hold `ore`=0 for 5 cycles → `dout` unchanged.
- **Masking:** WIDTH=16, LANE=8.
  - Write 0xAAAA to address 3, then mask 2'b01 with 0x1234 → read returns 0xAA34.
- **Collision, BYPASS=0:** M[5]=0x0011, `ra_d`=5, write 0x3FFF to 5 with `ore`=1 → `dout`=0x0011; next `ore` → 0x3FFF.
  - Repeat with BYPASS=1 → first `dout`=0x3FFF.
- **Non-power-of-2 depth:** DEPTH=48.
  - Write to address 50 → `wr_drop`=1 and M unchanged.
  - Read address 50 → `dout`=0.
- **Reset mid-sweep:** assert `rst` at cycle 20 of the sweep → `dout`=0 and `init_busy`=1.
  - After release, the full 64-cycle sweep reruns and all addresses read INIT_VAL.
